// File: rtl/tlc_conflict_monitor.sv
// tlc_conflict_monitor: traffic-light safety monitor with red-flash fault mode; `define TLC_YELLOW_CHECK_EN adds the short-yellow check
module tlc_conflict_monitor #(
  parameter int MIN_YELLOW      = 3,
  parameter int CONFLICT_FILTER = 2,
  parameter int FLASH_HALF      = 4,
  parameter int STARTUP_CYCLES  = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  input  logic       fault_reset,
  output logic [2:0] hwy_lamp,
  output logic [2:0] cntry_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_active
);
  typedef enum logic [1:0] {START, MONITOR, FLASH} state_t;
  localparam logic [2:0] RED = 3'b100;
  state_t state, state_n;
  logic [7:0] hold, hold_n, conf_cnt, conf_cnt_n, fcnt, fcnt_n;
  logic [2:0] hwy_lamp_n, cntry_lamp_n, fault_code_n, cause;
  logic [1:0] prev_hwy, prev_cntry, prev_hwy_n, prev_cntry_n;
  logic fault_n, phase, phase_n, both_go, conflict, invalid, skip, short_yel, recover;
  function automatic logic [2:0] decode(input logic [1:0] c);
    return c == 2'b00 ? 3'b100 : c == 2'b01 ? 3'b010 : c == 2'b10 ? 3'b001 : 3'b000;
  endfunction
  assign both_go  = (hwy == 2'b01 || hwy == 2'b10) && (cntry == 2'b01 || cntry == 2'b10);
  assign conflict = both_go && conf_cnt == 8'(CONFLICT_FILTER - 1);
  assign invalid  = hwy == 2'b11 || cntry == 2'b11;
  assign skip     = (prev_hwy == 2'b10 && hwy == 2'b00) || (prev_cntry == 2'b10 && cntry == 2'b00);
  assign recover  = fault_reset && hwy == 2'b00 && cntry == 2'b00;
`ifdef TLC_YELLOW_CHECK_EN
  logic [3:0] ycnt_h, ycnt_c;
  assign short_yel = (prev_hwy == 2'b01 && hwy == 2'b00 && 32'(ycnt_h) < MIN_YELLOW) ||
                     (prev_cntry == 2'b01 && cntry == 2'b00 && 32'(ycnt_c) < MIN_YELLOW);
  // yellow run-length per road, saturating; idle while flashing
  always_ff @(posedge clock) begin
    if (clear || state == FLASH) begin
      ycnt_h <= '0;
      ycnt_c <= '0;
    end else begin
      ycnt_h <= hwy == 2'b01 ? (ycnt_h == 4'hf ? ycnt_h : ycnt_h + 4'd1) : 4'd0;
      ycnt_c <= cntry == 2'b01 ? (ycnt_c == 4'hf ? ycnt_c : ycnt_c + 4'd1) : 4'd0;
    end
  end
`else
  assign short_yel = 1'b0 && (MIN_YELLOW > 0);
`endif
  assign cause = conflict ? 3'd1 : invalid ? 3'd2 : skip ? 3'd3 : short_yel ? 3'd4 : 3'd0;
  assign flash_active = state == FLASH;
  // next-state and next-output logic for the START/MONITOR/FLASH sequencer
  always_comb begin
    state_n      = state;
    hold_n       = hold;
    conf_cnt_n   = '0;
    fcnt_n       = fcnt;
    phase_n      = phase;
    hwy_lamp_n   = hwy_lamp;
    cntry_lamp_n = cntry_lamp;
    fault_n      = fault;
    fault_code_n = fault_code;
    prev_hwy_n   = prev_hwy;
    prev_cntry_n = prev_cntry;
    case (state)
      START: begin
        hwy_lamp_n   = RED;
        cntry_lamp_n = RED;
        prev_hwy_n   = hwy;
        prev_cntry_n = cntry;
        hold_n       = hold == 8'(STARTUP_CYCLES - 1) ? 8'd0 : hold + 8'd1;
        state_n      = hold == 8'(STARTUP_CYCLES - 1) ? MONITOR : START;
      end
      MONITOR: begin
        prev_hwy_n   = hwy;
        prev_cntry_n = cntry;
        conf_cnt_n   = both_go ? conf_cnt + 8'd1 : 8'd0;
        hwy_lamp_n   = decode(hwy);
        cntry_lamp_n = decode(cntry);
        if (cause != 3'd0) begin
          state_n      = FLASH;
          fault_n      = 1'b1;
          fault_code_n = cause;
          hwy_lamp_n   = RED;
          cntry_lamp_n = RED;
          phase_n      = 1'b1;
          fcnt_n       = '0;
          conf_cnt_n   = '0;
        end
      end
      default: begin
        fcnt_n       = fcnt == 8'(FLASH_HALF - 1) ? 8'd0 : fcnt + 8'd1;
        phase_n      = fcnt == 8'(FLASH_HALF - 1) ? ~phase : phase;
        hwy_lamp_n   = {phase_n, 2'b00};
        cntry_lamp_n = {phase_n, 2'b00};
        if (recover) begin
          state_n      = START;
          hold_n       = '0;
          fault_n      = 1'b0;
          fault_code_n = '0;
          hwy_lamp_n   = RED;
          cntry_lamp_n = RED;
          prev_hwy_n   = '0;
          prev_cntry_n = '0;
        end
      end
    endcase
  end
  // state and output registers with synchronous clear
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= START;
      hold       <= '0;
      conf_cnt   <= '0;
      fcnt       <= '0;
      phase      <= 1'b0;
      hwy_lamp   <= RED;
      cntry_lamp <= RED;
      fault      <= 1'b0;
      fault_code <= '0;
      prev_hwy   <= '0;
      prev_cntry <= '0;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      conf_cnt   <= conf_cnt_n;
      fcnt       <= fcnt_n;
      phase      <= phase_n;
      hwy_lamp   <= hwy_lamp_n;
      cntry_lamp <= cntry_lamp_n;
      fault      <= fault_n;
      fault_code <= fault_code_n;
      prev_hwy   <= prev_hwy_n;
      prev_cntry <= prev_cntry_n;
    end
  end
endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// tb_tlc_conflict_monitor: directed-vector bench for tlc_conflict_monitor
module tb_tlc_conflict_monitor;
  logic clock = 0, clear = 0, fault_reset = 0, fault, flash_active;
  logic [1:0] hwy = 0, cntry = 0;
  logic [2:0] hwy_lamp, cntry_lamp, fault_code;
  int n_vec = 0, n_bad = 0;
  tlc_conflict_monitor dut (
    .clock(clock), .clear(clear), .hwy(hwy), .cntry(cntry), .fault_reset(fault_reset),
    .hwy_lamp(hwy_lamp), .cntry_lamp(cntry_lamp), .fault(fault),
    .fault_code(fault_code), .flash_active(flash_active)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset(input logic [1:0] h, input logic [1:0] c);
    hwy = h;
    cntry = c;
    fault_reset = 0;
    clear = 1;
    step();
    clear = 0;
    repeat (5) step();
  endtask
  task automatic chk_all(input string tag, input logic [2:0] hl, input logic [2:0] cl,
                         input logic f, input logic [2:0] fc, input logic fa);
    chk({tag, "_hl"}, 8'(hwy_lamp), 8'(hl));
    chk({tag, "_cl"}, 8'(cntry_lamp), 8'(cl));
    chk({tag, "_f"}, 8'(fault), 8'(f));
    chk({tag, "_fc"}, 8'(fault_code), 8'(fc));
    chk({tag, "_fa"}, 8'(flash_active), 8'(fa));
  endtask
  initial begin
    hwy = 2'b10;
    cntry = 2'b00;
    clear = 1;
    step();
    clear = 0;
    chk_all("rst", 3'b100, 3'b100, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("start_hl", 8'(hwy_lamp), 8'b100);
    end
    step();
    chk_all("mon", 3'b001, 3'b100, 0, 0, 0);
    fault_reset = 1;
    step();
    chk_all("fr_mon", 3'b001, 3'b100, 0, 0, 0);
    fault_reset = 0;
    hwy = 2'b01;
    repeat (3) step();
    chk("yel3_hl", 8'(hwy_lamp), 8'b010);
    hwy = 2'b00;
    step();
    chk_all("yel3_ok", 3'b100, 3'b100, 0, 0, 0);
    do_reset(2'b10, 2'b00);
    hwy = 2'b01;
    repeat (2) step();
    hwy = 2'b00;
    step();
`ifdef TLC_YELLOW_CHECK_EN
    chk_all("short", 3'b100, 3'b100, 1, 3'd4, 1);
`else
    chk_all("short", 3'b100, 3'b100, 0, 0, 0);
`endif
    do_reset(2'b10, 2'b00);
    hwy = 2'b00;
    step();
    chk_all("skip", 3'b100, 3'b100, 1, 3'd3, 1);
    do_reset(2'b10, 2'b00);
    hwy = 2'b00;
    cntry = 2'b11;
    step();
    chk_all("inv", 3'b100, 3'b100, 1, 3'd2, 1);
    do_reset(2'b10, 2'b00);
    cntry = 2'b10;
    step();
    chk_all("conf1", 3'b001, 3'b001, 0, 0, 0);
    step();
    chk_all("conf2", 3'b100, 3'b100, 1, 3'd1, 1);
    hwy = 2'b01;
    cntry = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("flash_hl", 8'(hwy_lamp), (i < 4 || i == 8) ? 8'b100 : 8'b000);
      chk("flash_cl", 8'(cntry_lamp), (i < 4 || i == 8) ? 8'b100 : 8'b000);
    end
    chk("flash_fc", 8'(fault_code), 8'd1);
    fault_reset = 1;
    cntry = 2'b00;
    step();
    chk("fr_busy_fa", 8'(flash_active), 8'd1);
    chk("fr_busy_f", 8'(fault), 8'd1);
    hwy = 2'b00;
    step();
    chk_all("recov", 3'b100, 3'b100, 0, 0, 0);
    fault_reset = 0;
    hwy = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstart_hl", 8'(hwy_lamp), 8'b100);
    end
    step();
    chk_all("remon", 3'b001, 3'b100, 0, 0, 0);
    hwy = 2'b00;
    step();
    repeat (3) step();
    chk("mid_fa", 8'(flash_active), 8'd1);
    clear = 1;
    step();
    clear = 0;
    chk_all("clr_flash", 3'b100, 3'b100, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tlc_conflict_monitor.md
TLC_CONFLICT_MONITOR -- requirements
Module: tlc_conflict_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 3: minimum consecutive cycles a road must show YELLOW before RED.
REQ-002 Parameter CONFLICT_FILTER, default 2: consecutive cycles both roads are non-RED before a conflict fault.
REQ-003 Parameter FLASH_HALF, default 4: cycles per half-period of the fault red flash.
REQ-004 Parameter STARTUP_CYCLES, default 4: all-red hold after reset or recovery.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 clear  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-007 hwy  input  2  highway code from the controller: 00 RED, 01 YELLOW, 10 GREEN, 11 invalid.
REQ-008 cntry  input  2  country-road code, same encoding as hwy.
REQ-009 fault_reset  input  1  operator request to leave fault flash.
REQ-010 hwy_lamp  output  3  registered lamp drive {R,Y,G}, one-hot or all-zero.
REQ-011 cntry_lamp  output  3  registered lamp drive {R,Y,G}, one-hot or all-zero.
REQ-012 fault  output  1  latched fault indicator.
REQ-013 fault_code  output  3  latched cause: 000 none, 001 conflict, 010 invalid code, 011 green-to-red skipping yellow, 100 short yellow.
REQ-014 flash_active  output  1  high while in FLASH state.

Function
REQ-015 The FSM shall have the states START, MONITOR and FLASH.
REQ-016 In START, both lamps shall be 3'b100, the hold counter shall count STARTUP_CYCLES edges, and the FSM shall then enter MONITOR; no fault checks run in START.
REQ-017 In MONITOR, each lamp shall decode its input code with 1-cycle latency: 00->100, 01->010, 10->001.
REQ-018 Registers prev_hwy and prev_cntry shall capture the inputs on every edge in START and MONITOR.
REQ-019 Per-road yellow counters shall increment while the code is 01, saturate at 15, and reset to 0 on any other code.
REQ-020 A conflict counter shall increment while both codes are in {01,10} and reset otherwise; conflict fires when the counter reaches CONFLICT_FILTER-1 and both roads are still non-RED.
REQ-021 An invalid-code fault shall fire on any edge where either code is 11.
REQ-022 A skip fault shall fire when a road's previous code is 10 and its current code is 00.
REQ-023 A short-yellow fault shall fire when a road's previous code is 01, its current code is 00, and its yellow count is less than MIN_YELLOW.
REQ-024 Simultaneous faults shall be prioritised conflict > invalid > skip > short yellow; only the highest shall be latched into fault_code.
REQ-025 On the edge at which a fault fires in MONITOR: state<=FLASH, fault<=1, fault_code<=cause, both lamps<=100, flash phase<=lit, flash counter<=0.
REQ-026 In FLASH, the Y and G bits shall be 0, and the R bit of both lamps shall equal the flash phase, which toggles every FLASH_HALF cycles.
REQ-027 In FLASH, the inputs shall not affect the lamps, and further faults shall not alter fault_code.
REQ-028 In FLASH, if fault_reset=1 and hwy=00 and cntry=00 on the same edge, then the FSM shall enter START and fault, fault_code and flash_active shall clear; otherwise fault_reset shall be ignored.
REQ-029 fault_reset shall have no effect in START or MONITOR.
REQ-030 flash_active shall be 1 exactly when the state is FLASH.

Reset
REQ-031 With clear=1 at an edge: state=START, hold counter=0, hwy_lamp=cntry_lamp=100, fault=0, fault_code=000, flash_active=0, prev registers=00, all counters=0.
REQ-032 clear shall take priority over every other event, including when asserted mid-FLASH or mid-START.

Configuration
REQ-033 The macro TLC_YELLOW_CHECK_EN shall control the short-yellow check; when defined, the yellow counters and the short-yellow check (code 100) are compiled in.
REQ-034 Without TLC_YELLOW_CHECK_EN, the yellow counters shall be absent, code 100 shall never be produced, and all other behaviour shall be unchanged.

Verification
REQ-035 clear, then hwy=10, cntry=00 held -> lamps 100/100 for 4 cycles after the reset edge, then hwy_lamp=001, cntry_lamp=100.
REQ-036 In MONITOR, hwy=10 and cntry=10 for 2 cycles -> fault=1, fault_code=001, flash_active=1; R toggles every 4 cycles on both lamps.
REQ-037 In MONITOR, cntry=11 for 1 cycle -> fault_code=010 on the next edge.
REQ-038 hwy 10->00 with no yellow -> fault_code=011; hwy 10->01 for 2 cycles then 00 -> fault_code=100 (macro defined) or no fault (macro undefined).
REQ-039 In FLASH: fault_reset=1 with hwy=01 -> stays in FLASH; fault_reset=1 with both codes 00 -> START, fault=0, and MONITOR resumes after 4 cycles.
REQ-040 clear asserted mid-FLASH -> all outputs at reset values on the next edge.
